// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the framed byte-stream RAM loader.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'h55;
    localparam int unsigned MAX_LEN   = 16;

endpackage

// File: rtl/ram_loader_csum.sv
// Modulo-2^WIDTH payload accumulator with clear, add-enable and equality compare.
// Instantiated by ram_loader only when RAM_LOADER_CHECKSUM_EN is defined.
module ram_loader_csum #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_match
);

    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + i_data;
        end
    end

    assign o_match = (i_data == r_acc);

endmodule

// File: rtl/ram_loader.sv
// Framed byte-stream loader driving the program RAM write port and CPU hold.
// Optional checksum byte and accumulator enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // One extra bit so a full-depth count is representable.
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic                  r_hold;
    logic                  w_hold_next;
    logic                  r_error;
    logic                  w_error_next;
    logic                  r_we;
    logic                  w_we_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] w_wdata_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CNT_W-1:0]      r_remain;
    logic [CNT_W-1:0]      w_remain_next;

    logic                  w_accept;
    logic                  w_is_sync;
    logic                  w_len_ok;
    logic                  w_csum_clr;
    logic                  w_csum_add;

`ifdef RAM_LOADER_CHECKSUM_EN
    logic                  w_csum_match;

    ram_loader_csum #(
        .WIDTH (DATA_WIDTH)
    ) u_csum (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (w_csum_clr),
        .i_add   (w_csum_add),
        .i_data  (in_data),
        .o_match (w_csum_match)
    );
`endif

    // Held low through reset; only DONE refuses bytes.
    assign in_ready  = !reset && (r_state != StDone);
    assign w_accept  = in_valid && in_ready;
    assign w_is_sync = (in_data == DATA_WIDTH'(SYNC_BYTE));
    assign w_len_ok  = (in_data != '0) && (in_data <= DATA_WIDTH'(MAX_LEN));

    always_comb begin
        w_state_next  = r_state;
        w_hold_next   = r_hold;
        w_error_next  = r_error;
        w_we_next     = 1'b0;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_cnt_next    = r_cnt;
        w_remain_next = r_remain;
        w_csum_clr    = 1'b0;
        w_csum_add    = 1'b0;

        unique case (r_state)
            StIdle, StErr: begin
                if (w_accept && w_is_sync) begin
                    w_state_next = StLen;
                    w_hold_next  = 1'b1;
                    w_error_next = 1'b0;
                    w_csum_clr   = 1'b1;
                end
            end

            StLen: begin
                if (w_accept) begin
                    if (w_len_ok) begin
                        w_state_next  = StData;
                        w_remain_next = CNT_W'(in_data);
                        w_cnt_next    = '0;
                    end else begin
                        w_state_next = StErr;
                        w_hold_next  = 1'b0;
                        w_error_next = 1'b1;
                    end
                end
            end

            StData: begin
                if (w_accept) begin
                    w_we_next     = 1'b1;
                    w_addr_next   = r_cnt[ADDR_WIDTH-1:0];
                    w_wdata_next  = in_data;
                    w_cnt_next    = r_cnt + CNT_W'(1);
                    w_remain_next = r_remain - CNT_W'(1);
                    w_csum_add    = 1'b1;
                    if (r_remain == CNT_W'(1)) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                        w_state_next = StCsum;
`else
                        w_state_next = StDone;
                        w_hold_next  = 1'b0;
`endif
                    end
                end
            end

`ifdef RAM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (w_accept) begin
                    w_hold_next = 1'b0;
                    if (w_csum_match) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StErr;
                        w_error_next = 1'b1;
                    end
                end
            end
`endif

            StDone: begin
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
                w_hold_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_hold   <= 1'b0;
            r_error  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_remain <= '0;
        end else begin
            r_state  <= w_state_next;
            r_hold   <= w_hold_next;
            r_error  <= w_error_next;
            r_we     <= w_we_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
            r_cnt    <= w_cnt_next;
            r_remain <= w_remain_next;
        end
    end

    assign ram_we   = r_we;
    assign ram_addr = r_addr;
    assign ram_data = r_wdata;
    assign cpu_hold = r_hold;
    assign done     = (r_state == StDone);
    assign error    = r_error;

endmodule

// File: doc/ram_loader.md
# ram_loader

Byte-stream program loader that sits directly upstream of the 16-byte program RAM and drives its write port. It accepts a framed byte stream, typically from a UART receiver: sync byte, length, payload, checksum. It writes the payload into RAM starting at address 0 and holds the CPU halted while loading is in progress. At top level a mux selects the loader's write port over the CPU's RAM control whenever `cpu_hold` is high.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width; depth is 2**ADDR_WIDTH (16).
- `DATA_WIDTH`, default 8: byte width.
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_data`, input, 8: incoming stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader can accept a byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `ram_we`, output, 1: RAM write enable, registered.
- `ram_addr`, output, 4: RAM address, registered.
- `ram_data`, output, 8: RAM write data, registered.
- `cpu_hold`, output, 1: keeps the CPU halted and grants the RAM port to the loader.
- `done`, output, 1: one-cycle pulse on a successful load.
- `error`, output, 1: sticky frame-error flag.

## Operation
- Frame: `SYNC`=8'h55, then `LEN`, then `LEN` payload bytes, then `CSUM` (only when the checksum feature is compiled in).
- State IDLE:
  - `in_ready`=1.
  - Accepted byte 8'h55 → LEN: set `cpu_hold`=1, clear `error`, clear the accumulator.
  - Any other byte is discarded; stay in IDLE.
- State LEN:
  - Accepted byte in 1..16 → DATA; store the byte as the remaining count; address counter = 0.
  - Byte 0 or greater than 16 → ERR.
- State DATA:
  - Each accepted byte produces `ram_we`=1, `ram_addr`=counter, `ram_data`=byte in the next cycle.
  - Counter increments; accumulator += byte (mod 256).
  - After the `LEN`-th byte → CSUM, or → DONE if the checksum feature is compiled out.
- State CSUM:
  - Accepted byte equal to the accumulator → DONE.
  - Otherwise → ERR.
- State DONE: single cycle. `done`=1, `cpu_hold`→0, then → IDLE.
- State ERR:
  - `error`=1, `cpu_hold`→0, enter IDLE behaviour: `in_ready`=1 and wait for sync.
  - `error` stays set until the next accepted sync byte.
- Address wrap: impossible by construction, since `LEN` ≤ 16. The counter is 5 bits internally; `ram_addr` is its low 4 bits.
- RAM contents are never cleared by the loader. Bytes beyond `LEN` keep their prior values.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after release; `ram_we`=0, `ram_addr`=0, `ram_data`=0, `cpu_hold`=0, `done`=0, `error`=0; state = IDLE.
- Write latency: the `ram_we` pulse occurs exactly one cycle after the accepting edge. The RAM captures it on the following edge.
- `in_ready` stays 1 in IDLE, LEN, DATA and CSUM, so back-to-back bytes are accepted with one write per cycle. `in_ready` is 0 in DONE only.
- `ram_we` is high only in the cycle after a DATA-state acceptance. It is never asserted on SYNC, LEN or CSUM bytes.
- `cpu_hold` rises the cycle after sync is accepted. It falls in the same cycle that `done` or `error` asserts.
- `done` and `error` are never high together.
- Reset mid-frame: immediate return to reset values; the partially written RAM is left as-is.
- `in_valid` with `in_ready`=0: no transfer; the upstream source holds its byte.

## Configuration
- `RAM_LOADER_CHECKSUM_EN` defined:
  - CSUM state and accumulator present.
  - A frame is `LEN`+3 bytes.
  - A checksum mismatch sets `error`.
- Not defined:
  - No CSUM state or accumulator.
  - A frame is `LEN`+2 bytes.
  - DONE follows the last payload byte.
  - Errors come only from an invalid `LEN`.

## Structure
- Package `ram_loader_pkg`:
  - state enum `loader_state_t` (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - `SYNC_BYTE`=8'h55;
  - `MAX_LEN`=16.
- Sub-module `ram_loader_csum`: 8-bit modulo-256 accumulator with clear and add-enable, plus a compare output. It is instantiated only under `RAM_LOADER_CHECKSUM_EN`.

## Test plan
- Nominal load: after reset, stream 55 03 1F 4E E0 4D. Expect:
  - writes RAM[0]=1F, RAM[1]=4E, RAM[2]=E0 on consecutive cycles;
  - `done` pulses once;
  - `cpu_hold` high from the cycle after 55 until `done`.
- Bad checksum: stream 55 03 1F 4E E0 4C. Expect three writes, then `error`=1, no `done`, and `cpu_hold`=0. Then stream 55 01 AA AA: `error` clears on the sync, RAM[0]=AA, `done` pulses.
- Invalid length: streams 55 00 and 55 11 each give `error`=1 with zero `ram_we` pulses.
- Full 16-byte load: LEN=10 with payload 00..0F and checksum 78. Expect addresses 0..F written in order and no wrap.
- Garbage and stall: bytes 00 FF 54 before 55 are ignored. Toggle `in_valid` randomly during the frame: writes occur only on accepted bytes and the data/address sequence is unchanged.
- Reset mid-frame: assert `reset` after the second payload byte. All outputs go to reset values immediately and RAM[0..1] keep the written values. A fresh frame then loads normally.
